// File: rtl/ram_bubble_sorter_if.sv
// Sorter <-> RAM/host bundle: sort request/status plus split read and write RAM ports.
// Read port has one cycle of latency; the write lands at the clock edge where wren is high.
interface ram_bubble_sorter_if #(
    parameter int W = 8,
    parameter int A = 5
) ();
    logic         start;
    logic [A-1:0] rd_addr;
    logic [W-1:0] rd_data;
    logic [A-1:0] wr_addr;
    logic [W-1:0] wr_data;
    logic         wren;
    logic         busy;
    logic         done;
    logic [A-1:0] pass_cnt;

    modport master (
        input  start, rd_data,
        output rd_addr, wr_addr, wr_data, wren, busy, done, pass_cnt
    );

    modport slave (
        output start, rd_data,
        input  rd_addr, wr_addr, wr_data, wren, busy, done, pass_cnt
    );
endinterface

// File: rtl/ram_bubble_sorter.sv
// In-place ascending bubble sort of a 2**A x W RAM; 4 cycles per compare, 6 per swap.
// No backpressure; define SORT_EARLY_EXIT_EN to stop after the first pass without a swap.
module ram_bubble_sorter #(
    parameter int W = 8,
    parameter int A = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_bubble_sorter_if.master   bus
);
    typedef enum logic [2:0] {IDLE, RDA, RDB, CMP, WRA, WRB, NEXT, DONE} state_t;

    localparam logic [A-1:0] ONE  = A'(1);
    localparam logic [A-1:0] LAST = A'((1 << A) - 2);

    state_t       state_q, state_d;
    logic [A-1:0] i_q, i_d;
    logic [A-1:0] p_q, p_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic         swapped_q, swapped_d;
    logic [A-1:0] pass_cnt_q, pass_cnt_d;
    logic [A-1:0] rd_addr_q, rd_addr_d;
    logic [A-1:0] wr_addr_q, wr_addr_d;
    logic [W-1:0] wr_data_q, wr_data_d;
    logic         wren_q, wren_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [A-1:0] last_i;
    logic         sort_over;

    // Last left-hand index of the current pass shrinks as the tail settles.
    assign last_i = LAST - p_q;

`ifdef SORT_EARLY_EXIT_EN
    assign sort_over = (p_q == LAST) || !swapped_q;
`else
    assign sort_over = (p_q == LAST);
    logic unused_swapped;
    assign unused_swapped = swapped_q;
`endif

    // b is captured for visibility only; the WRA data is taken straight off rd_data.
    logic unused_b;
    assign unused_b = ^b_q;

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        p_d        = p_q;
        a_d        = a_q;
        b_d        = b_q;
        swapped_d  = swapped_q;
        pass_cnt_d = pass_cnt_q;
        rd_addr_d  = rd_addr_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wren_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = done_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d    = RDA;
                    i_d        = '0;
                    p_d        = '0;
                    swapped_d  = 1'b0;
                    pass_cnt_d = '0;
                    rd_addr_d  = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end
            end
            RDA: begin
                state_d   = RDB;
                rd_addr_d = i_q + ONE;
            end
            RDB: begin
                state_d = CMP;
                a_d     = bus.rd_data;
            end
            CMP: begin
                b_d = bus.rd_data;
                if (a_q > bus.rd_data) begin
                    state_d   = WRA;
                    wren_d    = 1'b1;
                    wr_addr_d = i_q;
                    wr_data_d = bus.rd_data;
                end else begin
                    state_d = NEXT;
                end
            end
            WRA: begin
                state_d   = WRB;
                swapped_d = 1'b1;
                wren_d    = 1'b1;
                wr_addr_d = i_q + ONE;
                wr_data_d = a_q;
            end
            WRB: begin
                state_d = NEXT;
            end
            NEXT: begin
                if (i_q < last_i) begin
                    state_d   = RDA;
                    i_d       = i_q + ONE;
                    rd_addr_d = i_q + ONE;
                end else begin
                    pass_cnt_d = pass_cnt_q + ONE;
                    p_d        = p_q + ONE;
                    i_d        = '0;
                    swapped_d  = 1'b0;
                    rd_addr_d  = '0;
                    if (sort_over) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RDA;
                    end
                end
            end
            DONE: begin
                if (!bus.start) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            i_q        <= '0;
            p_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            swapped_q  <= 1'b0;
            pass_cnt_q <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wren_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            p_q        <= p_d;
            a_q        <= a_d;
            b_q        <= b_d;
            swapped_q  <= swapped_d;
            pass_cnt_q <= pass_cnt_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wren_q     <= wren_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.rd_addr  = rd_addr_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.wren     = wren_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass_cnt = pass_cnt_q;
endmodule

// File: tb/tb_ram_bubble_sorter.sv
// Bench for ram_bubble_sorter: behavioural 32x8 RAM, array-level bubble-sort reference, per-cycle write checks.
module tb_ram_bubble_sorter;
    localparam int W = 8;
    localparam int A = 5;
    localparam int N = 32;
`ifdef SORT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_bubble_sorter_if #(.W(W), .A(A)) bus ();
    ram_bubble_sorter #(.W(W), .A(A)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [W-1:0] mem [N];
    logic [W-1:0] load_dat [N];
    logic         load_req = 1'b0;

    always @(posedge clk) begin
        if (load_req) begin
            for (int k = 0; k < N; k++) mem[k] <= load_dat[k];
        end else if (bus.wren) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        bus.rd_data <= mem[bus.rd_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int busy_cyc, wren_cyc, swaps;
    bit prev_wren;
    int pend_addr;
    logic [W-1:0] pend_a;

    logic [W-1:0] mdl [N];
    int m_pass, m_cmp, m_sw;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    // Reference: plain bubble sort over an array copy, counting passes, compares and swaps.
    task automatic model_run();
        logic [W-1:0] t;
        bit sw;
        m_pass = 0; m_cmp = 0; m_sw = 0;
        for (int p = 0; p < N - 1; p++) begin
            sw = 1'b0;
            for (int i = 0; i < N - 1 - p; i++) begin
                m_cmp++;
                if (mdl[i] > mdl[i+1]) begin
                    t = mdl[i]; mdl[i] = mdl[i+1]; mdl[i+1] = t;
                    m_sw++;
                    sw = 1'b1;
                end
            end
            m_pass++;
            if (EE && !sw) break;
        end
    endtask

    // One cycle: sample at negedge and check that every write pair is a strict adjacent swap.
    task automatic tick();
        int ia;
        @(negedge clk);
        chk("busy_done_exclusive", {31'b0, bus.busy & bus.done}, 32'd0);
        chk("wren_only_when_busy", {31'b0, bus.wren & ~bus.busy}, 32'd0);
        if (bus.busy) busy_cyc++;
        if (bus.wren) begin
            wren_cyc++;
            ia = int'(bus.wr_addr);
            if (!prev_wren) begin
                swaps++;
                chk("first_write_addr_range", {31'b0, ia < N - 1}, 32'd1);
                if (ia < N - 1) begin
                    chk("first_write_data", {24'b0, bus.wr_data}, {24'b0, mem[ia+1]});
                    chk("first_write_strict_order", {31'b0, mem[ia] > bus.wr_data}, 32'd1);
                    pend_a = mem[ia];
                end
                pend_addr = ia;
            end else begin
                chk("second_write_addr", ia, pend_addr + 1);
                chk("second_write_data", {24'b0, bus.wr_data}, {24'b0, pend_a});
            end
        end
        prev_wren = bus.wren;
    endtask

    task automatic load_ram();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic run_case(input string nm, input int drop_after);
        for (int k = 0; k < N; k++) mdl[k] = mem[k];
        model_run();
        busy_cyc = 0; wren_cyc = 0; swaps = 0;
        bus.start = 1'b1;
        tick();
        chk({nm, "_busy_after_start"}, {31'b0, bus.busy}, 32'd1);
        for (int c = 0; c < 6000 && !bus.done; c++) begin
            if (c == drop_after) bus.start = 1'b0;
            tick();
        end
        chk({nm, "_done"}, {31'b0, bus.done}, 32'd1);
        chk({nm, "_busy_at_done"}, {31'b0, bus.busy}, 32'd0);
        chk({nm, "_pass_cnt"}, {27'b0, bus.pass_cnt}, m_pass);
        chk({nm, "_swaps"}, swaps, m_sw);
        chk({nm, "_wren_cycles"}, wren_cyc, 2 * m_sw);
        chk({nm, "_busy_cycles"}, busy_cyc, 4 * m_cmp + 2 * m_sw);
        for (int k = 0; k < N; k++) chk({nm, "_mem"}, {24'b0, mem[k]}, {24'b0, mdl[k]});
    endtask

    task automatic finish_case(input string nm);
        bus.start = 1'b0;
        tick();
        chk({nm, "_done_cleared"}, {31'b0, bus.done}, 32'd0);
        chk({nm, "_idle_busy"}, {31'b0, bus.busy}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        prev_wren = 1'b0;
        pend_addr = 0;
        pend_a = '0;
        busy_cyc = 0; wren_cyc = 0; swaps = 0;
        @(posedge clk);
        tick();
        chk("rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("rst_done", {31'b0, bus.done}, 32'd0);
        chk("rst_wren", {31'b0, bus.wren}, 32'd0);
        chk("rst_rd_addr", {27'b0, bus.rd_addr}, 32'd0);
        chk("rst_wr_addr", {27'b0, bus.wr_addr}, 32'd0);
        chk("rst_wr_data", {24'b0, bus.wr_data}, 32'd0);
        chk("rst_pass_cnt", {27'b0, bus.pass_cnt}, 32'd0);
        reset = 1'b0;
        tick();

        // Already ascending: no writes at all.
        for (int k = 0; k < N; k++) load_dat[k] = W'(k);
        load_ram();
        run_case("asc", -1);
        chk("asc_no_swaps", swaps, 32'd0);
        chk("asc_pass_cnt_lit", {27'b0, bus.pass_cnt}, EE ? 32'd1 : 32'd31);

        // start held high after completion must not re-sort.
        busy_cyc = 0; wren_cyc = 0;
        for (int c = 0; c < 100; c++) tick();
        chk("hold_no_wren", wren_cyc, 32'd0);
        chk("hold_no_busy", busy_cyc, 32'd0);
        chk("hold_done_stays", {31'b0, bus.done}, 32'd1);
        bus.start = 1'b0;
        tick();
        chk("hold_release_done", {31'b0, bus.done}, 32'd0);
        run_case("resort", -1);
        finish_case("resort");

        // Fully descending: worst case.
        for (int k = 0; k < N; k++) load_dat[k] = W'(N - 1 - k);
        load_ram();
        run_case("desc", -1);
        chk("desc_swaps_lit", swaps, 32'd496);
        chk("desc_wren_lit", wren_cyc, 32'd992);
        chk("desc_pass_lit", {27'b0, bus.pass_cnt}, 32'd31);
        for (int k = 0; k < N; k++) chk("desc_mem_lit", {24'b0, mem[k]}, k);
        finish_case("desc");

        // All 0xFF with a single zero at the top address.
        for (int k = 0; k < N; k++) load_dat[k] = 8'hFF;
        load_dat[N-1] = 8'h00;
        load_ram();
        run_case("ff", -1);
        chk("ff_mem0_lit", {24'b0, mem[0]}, 32'h00);
        chk("ff_mem31_lit", {24'b0, mem[N-1]}, 32'hFF);
        chk("ff_swaps_lit", swaps, 32'd31);
        finish_case("ff");

        // Duplicates; start drops mid-sort so done must be a single-cycle pulse.
        for (int k = 0; k < N; k++) load_dat[k] = W'((k * 13) % 6);
        load_dat[0] = 8'd5; load_dat[1] = 8'd5; load_dat[2] = 8'd3;
        load_ram();
        run_case("dup", 10);
        tick();
        chk("dup_done_one_cycle", {31'b0, bus.done}, 32'd0);
        chk("dup_idle_busy", {31'b0, bus.busy}, 32'd0);

        // Reset in the middle of pass 3 of a descending sort, then a clean restart.
        for (int k = 0; k < N; k++) load_dat[k] = W'(N - 1 - k);
        load_ram();
        bus.start = 1'b1;
        tick();
        for (int c = 0; c < 4000 && !(bus.pass_cnt == 5'd3 && !bus.wren && bus.busy); c++) tick();
        chk("mid_reached_pass3", {27'b0, bus.pass_cnt}, 32'd3);
        for (int c = 0; c < 40; c++) tick();
        for (int c = 0; c < 10 && bus.wren; c++) tick();
        reset = 1'b1;
        bus.start = 1'b0;
        tick();
        chk("mid_rst_busy", {31'b0, bus.busy}, 32'd0);
        chk("mid_rst_pass_cnt", {27'b0, bus.pass_cnt}, 32'd0);
        chk("mid_rst_done", {31'b0, bus.done}, 32'd0);
        chk("mid_rst_wren", {31'b0, bus.wren}, 32'd0);
        reset = 1'b0;
        tick();
        chk("mid_stays_idle", {31'b0, bus.busy}, 32'd0);
        run_case("restart", -1);
        for (int k = 0; k < N; k++) chk("restart_mem_lit", {24'b0, mem[k]}, k);
        finish_case("restart");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
